// File: rtl/mem_pkg.sv
// Shared size encodings and byte-lane helpers for the data memory and the LSU.
// Lane 0 is the most significant byte of a word (big-endian).
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // be[i] enables lane i. Alignment is not checked here; callers gate on error.
  function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                              input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data so every lane sees its byte at [31-8*lane -: 8].
  function automatic logic [31:0] steer_wdata(input logic [1:0]  size,
                                              input logic [31:0] wdata);
    logic [31:0] lanes;
    lanes = wdata;
    case (size)
      SZ_BYTE: lanes = {4{wdata[7:0]}};
      SZ_HALF: lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic        is_unsigned,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[15:0] : word[31:16];
    r = 32'h0;
    case (size)
      SZ_BYTE: r = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram_byte_bank.sv
// One byte lane of the data memory: synchronous write, registered read.
// Contents are never reset.
module ram_byte_bank #(
  parameter int ENTRIES = 1024,
  parameter int IDX_W   = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_ram.sv
// Byte-addressed big-endian data memory with byte/half/word access, sign/zero
// extension, per-byte write enables and alignment/range error reporting.
module data_ram
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = 32,
  parameter int INIT_ZERO   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW      = $clog2(DEPTH_BYTES);
  localparam int ENTRIES = DEPTH_BYTES / 4;
  localparam int IDX_W   = (AW > 2) ? AW - 2 : 1;

  if (DEPTH_BYTES < 4 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0 ||
      ADDR_W < AW || INIT_ZERO < 0 || INIT_ZERO > 1) begin : g_bad_params
    $error("data_ram: illegal parameter combination");
  end

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             misaligned;
  logic             out_of_range;
  logic             err;
  logic             fire;
  logic [3:0]       be;
  logic [3:0]       bank_we;
  logic             bank_en;
  logic [31:0]      lane_wdata;
  logic [31:0]      rd_word;

  logic             p_valid;
  logic             p_err;
  logic             p_load;
  logic             p_unsigned;
  logic [1:0]       p_size;
  logic [1:0]       p_lane;

  assign lane = req_addr[1:0];

  if (AW > 2) begin : g_idx
    assign idx = req_addr[AW-1:2];
  end else begin : g_idx_single
    assign idx = '0;
  end

  // Compare one bit wider so the full address range is checked without aliasing.
  assign out_of_range = {1'b0, req_addr} >= (ADDR_W + 1)'(DEPTH_BYTES);
  assign misaligned   = ((req_size == SZ_HALF) && lane[0]) ||
                        ((req_size == SZ_WORD) && (lane != 2'b00));
  assign err          = misaligned || out_of_range || (req_size == SZ_RSVD);

  // A request seen while reset is asserted is dropped entirely.
  assign fire       = rst_n && req_valid;
  assign be         = byte_enables(req_size, lane);
  assign bank_we    = (fire && req_we && !err) ? be : 4'b0000;
  assign bank_en    = fire && !req_we && !err;
  assign lane_wdata = steer_wdata(req_size, req_wdata);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    ram_byte_bank #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
    ) u_bank (
      .clk   (clk),
      .en    (bank_en),
      .we    (bank_we[i]),
      .addr  (idx),
      .wdata (lane_wdata[31-8*i -: 8]),
      .rdata (rd_word[31-8*i -: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_valid    <= 1'b0;
      p_err      <= 1'b0;
      p_load     <= 1'b0;
      p_unsigned <= 1'b0;
      p_size     <= SZ_BYTE;
      p_lane     <= 2'b00;
    end else begin
      p_valid    <= req_valid;
      p_err      <= req_valid && err;
      p_load     <= req_valid && !req_we && !err;
      p_unsigned <= req_unsigned;
      p_size     <= req_size;
      p_lane     <= lane;
    end
  end

  // Bank read registers hold stale data on stores/errors/idle; p_load masks them.
  assign rsp_valid = p_valid;
  assign rsp_err   = p_err;
  assign rsp_rdata = p_load ? load_extend(p_size, p_unsigned, p_lane, rd_word) : 32'h0;

endmodule
